regfile_wr_arbiter: RTL

//   Shares the two write ports of regfile_16x32b_4rd_2wr among NREQ write requesters.

---
 rtl/regfile_wr_arbiter_if.sv | 41 ++++
 rtl/regfile_wr_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle between the write requesters, the arbiter and the register file write ports.
// The requesters hold the master modport and the arbiter holds the slave modport.
//
// Handshake: requester i raises req_valid[i] with req_addr/req_data for that slot and
// keeps all three stable until it sees req_ready[i]. A transfer happens on the rising
// edge where req_valid[i] & req_ready[i] are both 1. After that edge the requester may
// drop valid or present its next write.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic [AW-1:0]      wrport1_ctrl_add;
    logic [DW-1:0]      wrport1_data_in;
    logic               wrport1_wren;
    logic [AW-1:0]      wrport2_ctrl_add;
    logic [DW-1:0]      wrport2_data_in;
    logic               wrport2_wren;
    logic               arb_busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  wrport1_ctrl_add, wrport1_data_in, wrport1_wren,
        input  wrport2_ctrl_add, wrport2_data_in, wrport2_wren,
        input  arb_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output wrport1_ctrl_add, wrport1_data_in, wrport1_wren,
        output wrport2_ctrl_add, wrport2_data_in, wrport2_wren,
        output arb_busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 2-write-port register file.
// Each cycle grants up to two requesters in round-robin order starting at rr_ptr:
// grant A is the first valid requester, grant B the next valid one whose address
// differs from A's. Same-address requesters stall, so the two write ports never
// target the same register. Grants are registered onto wrport1 (A) and wrport2 (B).
// Build option: define ARB_FIXED_PRIO_EN to pin rr_ptr at 0 (fixed priority,
// requester 0 highest); left undefined, arbitration is round-robin.
module regfile_wr_arbiter #(
    parameter int  NREQ = 4,
    parameter int  AW   = 4,
    parameter int  DW   = 32,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wr_arbiter_if.slave bus,
    output logic [PW-1:0]       dbg_rr_ptr_o
);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic            a_found, b_found;
    logic [PW-1:0]   a_idx, b_idx, cand;
    logic [NREQ-1:0] ready;

    logic [AW-1:0]   wr1_add_q, wr2_add_q;
    logic [DW-1:0]   wr1_data_q, wr2_data_q;
    logic            wr1_wren_q, wr2_wren_q;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Unpack the flat request buses into per-requester slots.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = bus.req_addr[i*AW +: AW];
            data_arr[i] = bus.req_data[i*DW +: DW];
        end
    end

    // Walk requesters from rr_ptr; pick A, then the first later B with a different address.
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (rst && bus.req_valid[cand]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = cand;
                end else if (!b_found && (addr_arr[cand] != addr_arr[a_idx])) begin
                    b_found = 1'b1;
                    b_idx   = cand;
                end
            end
        end
    end

    // One-hot-or-two ready vector for the chosen grants.
    always_comb begin
        ready = '0;
        if (a_found) ready[a_idx] = 1'b1;
        if (b_found) ready[b_idx] = 1'b1;
    end

    // Next search start: one past the last granted requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        if (b_found) begin
            rr_ptr_d = inc_wrap(b_idx);
        end else if (a_found) begin
            rr_ptr_d = inc_wrap(a_idx);
        end
`endif
    end

    // Register grants onto the write ports; address/data hold when a port is idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            wr1_add_q  <= '0;
            wr1_data_q <= '0;
            wr1_wren_q <= 1'b0;
            wr2_add_q  <= '0;
            wr2_data_q <= '0;
            wr2_wren_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr1_wren_q <= a_found;
            wr2_wren_q <= b_found;
            if (a_found) begin
                wr1_add_q  <= addr_arr[a_idx];
                wr1_data_q <= data_arr[a_idx];
            end
            if (b_found) begin
                wr2_add_q  <= addr_arr[b_idx];
                wr2_data_q <= data_arr[b_idx];
            end
        end
    end

    assign bus.req_ready        = ready;
    assign bus.wrport1_ctrl_add = wr1_add_q;
    assign bus.wrport1_data_in  = wr1_data_q;
    assign bus.wrport1_wren     = wr1_wren_q;
    assign bus.wrport2_ctrl_add = wr2_add_q;
    assign bus.wrport2_data_in  = wr2_data_q;
    assign bus.wrport2_wren     = wr2_wren_q;
    assign bus.arb_busy         = wr1_wren_q | wr2_wren_q;
    assign dbg_rr_ptr_o         = rr_ptr_q;

endmodule
